// File: rtl/bsg_link_upstream_arbiter.sv
// Round-robin, burst-limited arbiter that merges num_req_p requester streams onto one upstream link.
// Optional macro BSG_LINK_ARB_TAG_EN adds link_tag_o, which carries the granted requester index.

module bsg_link_upstream_arbiter_lane #(
  parameter int width_p = 64
) (
  input  logic               sel,
  input  logic [width_p-1:0] data,
  input  logic               valid,
  input  logic               link_ready,
  output logic               ready,
  output logic [width_p-1:0] data_g,
  output logic               valid_g
);
  // Lanes that are not selected contribute zero, so the top can OR the lanes together.
  assign ready   = sel & link_ready;
  assign valid_g = sel & valid;
  assign data_g  = sel ? data : '0;
endmodule

module bsg_link_upstream_arbiter #(
  parameter int num_req_p   = 4,
  parameter int width_p     = 64,
  parameter int burst_max_p = 8
) (
  input  logic                         core_clk_i,
  input  logic                         core_reset_n_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]         req_valid_i,
  input  logic [num_req_p-1:0]         req_last_i,
  output logic [num_req_p-1:0]         req_ready_o,
  output logic [width_p-1:0]           link_data_o,
  output logic                         link_valid_o,
  input  logic                         link_ready_i
`ifdef BSG_LINK_ARB_TAG_EN
  , output logic [$clog2(num_req_p)-1:0] link_tag_o
`endif
);
  localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w = $clog2(burst_max_p + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                               state;
  logic [idx_w-1:0]                     grant, rr_ptr;
  logic [cnt_w-1:0]                     cnt;

  logic [num_req_p-1:0]                 sel;
  logic [num_req_p-1:0][width_p-1:0]    data_g;
  logic [num_req_p-1:0]                 valid_g;
  logic [idx_w-1:0]                     pick_idx;
  logic                                 pick_vld;
  logic                                 xfer, grant_end;
  logic [idx_w-1:0]                     rr_nxt;

  for (genvar i = 0; i < num_req_p; i++) begin : g_lane
    assign sel[i] = (state == GRANT) && (grant == idx_w'(i));
    bsg_link_upstream_arbiter_lane #(.width_p(width_p)) u_lane (
      .sel        (sel[i]),
      .data       (req_data_i[i*width_p +: width_p]),
      .valid      (req_valid_i[i]),
      .link_ready (link_ready_i),
      .ready      (req_ready_o[i]),
      .data_g     (data_g[i]),
      .valid_g    (valid_g[i])
    );
  end

  always_comb begin
    link_data_o  = '0;
    link_valid_o = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      link_data_o  = link_data_o | data_g[i];
      link_valid_o = link_valid_o | valid_g[i];
    end
  end

  // Scan from the far end toward rr_ptr so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (req_valid_i[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx_w'(idx);
      end
    end
  end

  assign xfer      = link_valid_o & link_ready_i;
  assign grant_end = xfer && (req_last_i[grant] || (cnt == cnt_w'(burst_max_p - 1)));
  assign rr_nxt    = (grant == idx_w'(num_req_p - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= rr_nxt;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BSG_LINK_ARB_TAG_EN
  assign link_tag_o = (state == GRANT) ? grant : '0;
`endif
endmodule
